// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signals of the ALU front-end sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready_c;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_carry;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [12:0]      alu_instruc;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_result_hi;
    logic             alu_carry;

    logic             busy;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  rsp_ready, alu_result, alu_result_hi, alu_carry,
        output req_ready_c, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_err,
        output alu_a, alu_b, alu_instruc, busy
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output rsp_ready, alu_result, alu_result_hi, alu_carry,
        input  req_ready_c, rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_carry, rsp_err,
        input  alu_a, alu_b, alu_instruc, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin two-requester front end for the one-hot-select ALU: decodes the
// opcode, holds operands for the op latency and keeps the response until taken.
module alu_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic            clock_i,
    input  logic            clear_n_i,
    alu_sequencer_if.slave  bus
);
    localparam int unsigned SEL_W = 13;
    localparam int unsigned CNT_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [3:0]  OP_MUL  = 4'd4;
    localparam logic [3:0]  OP_DIV  = 4'd5;
    localparam logic [3:0]  OP_LAST = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               own_q, own_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_instruc_q, alu_instruc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_lo_q, rsp_lo_d;
    logic [WIDTH-1:0]   rsp_hi_q, rsp_hi_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic [1:0]         grant_c;
    logic [3:0]         sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Next-state, arbitration and response capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        own_d         = own_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_instruc_d = alu_instruc_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_lo_d      = rsp_lo_q;
        rsp_hi_d      = rsp_hi_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_err_d     = rsp_err_q;
        grant_c       = 2'b00;
        sel_op        = bus.req_op0;
        sel_a         = bus.req_a0;
        sel_b         = bus.req_b0;

        unique case (state_q)
            S_IDLE: begin
                case (bus.req_valid)
                    2'b01:   grant_c = 2'b01;
                    2'b10:   grant_c = 2'b10;
                    2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
                    default: grant_c = 2'b00;
                endcase
                if (grant_c[1]) begin
                    sel_op = bus.req_op1;
                    sel_a  = bus.req_a1;
                    sel_b  = bus.req_b1;
                end
                if (grant_c != 2'b00) begin
                    own_d = grant_c[1];
                    if (sel_op > OP_LAST) begin
                        // Illegal opcode bypasses the ALU entirely.
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_lo_d    = '0;
                        rsp_hi_d    = '0;
                        rsp_carry_d = 1'b0;
                        rsp_id_d    = grant_c[1];
                    end else begin
                        state_d       = S_EXEC;
                        cnt_d         = (sel_op == OP_MUL || sel_op == OP_DIV) ?
                                        CNT_W'(MULDIV_CYCLES) : CNT_W'(1);
                        alu_instruc_d = SEL_W'(1) << sel_op;
                        alu_a_d       = sel_a;
                        alu_b_d       = sel_b;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d       = S_DONE;
                    rsp_valid_d   = 1'b1;
                    rsp_lo_d      = bus.alu_result;
                    rsp_hi_d      = bus.alu_result_hi;
                    rsp_carry_d   = bus.alu_carry;
                    rsp_err_d     = 1'b0;
                    rsp_id_d      = own_q;
                    alu_instruc_d = '0;
                    alu_a_d       = '0;
                    alu_b_d       = '0;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            own_q         <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_instruc_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_lo_q      <= '0;
            rsp_hi_q      <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            own_q         <= own_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_instruc_q <= alu_instruc_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_lo_q      <= rsp_lo_d;
            rsp_hi_q      <= rsp_hi_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
        end
    end

    // Ready is gated by reset so it reads 0 while clear_n is low.
    assign bus.req_ready_c = grant_c & {2{clear_n_i}};
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_lo      = rsp_lo_q;
    assign bus.rsp_hi      = rsp_hi_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_instruc = alu_instruc_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level model, directed
// cases with literal expectations, then randomized two-requester traffic.
module tb_alu_sequencer;
    localparam int MC = 4;

    logic clock = 1'b0;
    logic clear_n;
    int   tests = 0;
    int   fails = 0;

    alu_sequencer_if #(.WIDTH(32)) bus();

    alu_sequencer #(.WIDTH(32), .MULDIV_CYCLES(MC)) dut (
        .clock_i   (clock),
        .clear_n_i (clear_n),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // Reference ALU: returns {carry, hi, lo}.
    function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] w;
        logic [63:0] t;
        logic        c;
        logic [4:0]  s;
        s = b[4:0];
        w = '0;
        c = 1'b0;
        t = {a, a};
        case (op)
            4'd0:  w[31:0] = a & b;
            4'd1:  w[31:0] = a | b;
            4'd2:  {c, w[31:0]} = {1'b0, a} + {1'b0, b};
            4'd3:  begin w[31:0] = a - b; c = (a >= b); end
            4'd4:  w = {32'd0, a} * {32'd0, b};
            4'd5:  w = (b != 0) ? {a % b, a / b} : {a, 32'hFFFF_FFFF};
            4'd6:  w[31:0] = a >> s;
            4'd7:  w[31:0] = 32'($signed(a) >>> s);
            4'd8:  w[31:0] = a << s;
            4'd9:  begin t = t >> s; w[31:0] = t[31:0]; end
            4'd10: begin t = t << s; w[31:0] = t[63:32]; end
            4'd11: w[31:0] = -a;
            4'd12: w[31:0] = ~a;
            default: w = '0;
        endcase
        return {c, w};
    endfunction

    // The ALU itself, driven from whatever the sequencer presents.
    logic [3:0]  alu_idx;
    logic [64:0] alu_res;
    always_comb begin
        alu_idx = '0;
        for (int i = 0; i < 13; i++)
            if (bus.alu_instruc[i]) alu_idx = 4'(i);
        alu_res = (bus.alu_instruc == '0) ? '0 : ref_alu(alu_idx, bus.alu_a, bus.alu_b);
    end
    assign bus.alu_result    = alu_res[31:0];
    assign bus.alu_result_hi = alu_res[63:32];
    assign bus.alu_carry     = alu_res[64];

    // Transaction-level model state.
    int          m_rem;
    bit          m_pend, m_last, m_id, m_rid, m_c, m_err;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_lo, m_hi;
    logic [1:0]  tb_granted;

    task automatic model_reset();
        m_rem = 0; m_pend = 0; m_last = 1; m_id = 0; m_rid = 0;
        m_c = 0; m_err = 0; m_op = '0; m_a = '0; m_b = '0; m_lo = '0; m_hi = '0;
        tb_granted = 2'b00;
    endtask

    function automatic logic [1:0] arb(input logic [1:0] v, input bit last);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against model at negedge, advance model, return at posedge+1.
    task automatic step();
        logic [1:0]  g;
        logic [3:0]  op;
        logic [64:0] r;
        bit          ebusy;
        @(negedge clock);
        ebusy = (m_rem != 0) || m_pend;
        g = (ebusy || !clear_n) ? 2'b00 : arb(bus.req_valid, m_last);
        chk("req_ready", 64'(bus.req_ready_c), 64'(g));
        chk("busy", 64'(bus.busy), 64'(ebusy));
        chk("alu_instruc", 64'(bus.alu_instruc), (m_rem != 0) ? 64'(13'd1 << m_op) : 64'd0);
        chk("alu_a", 64'(bus.alu_a), (m_rem != 0) ? 64'(m_a) : 64'd0);
        chk("alu_b", 64'(bus.alu_b), (m_rem != 0) ? 64'(m_b) : 64'd0);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend));
        if (m_pend) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_rid));
            chk("rsp_lo", 64'(bus.rsp_lo), 64'(m_lo));
            chk("rsp_hi", 64'(bus.rsp_hi), 64'(m_hi));
            chk("rsp_carry", 64'(bus.rsp_carry), 64'(m_c));
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        end
        if (m_rem != 0) begin
            m_rem--;
            if (m_rem == 0) begin
                r = ref_alu(m_op, m_a, m_b);
                m_lo = r[31:0]; m_hi = r[63:32]; m_c = r[64];
                m_err = 0; m_rid = m_id; m_pend = 1;
            end
        end else if (m_pend) begin
            if (bus.rsp_ready) begin
                m_pend = 0;
                m_last = m_rid;
            end
        end else if (g != 2'b00) begin
            m_id = g[1];
            op = g[1] ? bus.req_op1 : bus.req_op0;
            if (op > 4'd12) begin
                m_pend = 1; m_err = 1; m_lo = '0; m_hi = '0; m_c = 0; m_rid = m_id;
            end else begin
                m_op = op;
                m_a  = g[1] ? bus.req_a1 : bus.req_a0;
                m_b  = g[1] ? bus.req_b1 : bus.req_b0;
                m_rem = (op == 4'd4 || op == 4'd5) ? MC : 1;
            end
        end
        tb_granted = g;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (r == 0) begin
            bus.req_valid[0] = 1'b1; bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_valid[1] = 1'b1; bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    task automatic wait_rsp(input int max);
        for (int i = 0; i < max && !bus.rsp_valid; i++) step();
        chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_c), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_lo", 64'(bus.rsp_lo), 64'd0);
        chk("rst_rsp_hi", 64'(bus.rsp_hi), 64'd0);
        chk("rst_rsp_flags", 64'({bus.rsp_carry, bus.rsp_err}), 64'd0);
        chk("rst_alu_ab", 64'({bus.alu_a, bus.alu_b}), 64'd0);
        chk("rst_alu_instruc", 64'(bus.alu_instruc), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        bus.req_valid = 2'b00;
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.rsp_ready = 1'b1;
        clear_n = 1'b0;
        #2;
        do_reset();

        // ADD with carry out, single EXEC cycle.
        set_req(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        bus.req_valid = 2'b00;
        chk("add_instruc", 64'(bus.alu_instruc), 64'h4);
        chk("add_not_yet", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("add_valid", 64'(bus.rsp_valid), 64'd1);
        chk("add_lo", 64'(bus.rsp_lo), 64'hFFFF_FFFE);
        chk("add_carry", 64'(bus.rsp_carry), 64'd1);
        chk("add_id", 64'(bus.rsp_id), 64'd0);
        chk("add_instruc_off", 64'(bus.alu_instruc), 64'h0);
        step();

        // MUL from requester 1, operands held while req_a1 wiggles.
        set_req(1, 4'd4, 32'h0005_4351, 32'h0000_4351);
        step();
        bus.req_valid = 2'b00;
        for (int k = 0; k < MC; k++) begin
            bus.req_a1 = $urandom;
            chk("mul_instruc", 64'(bus.alu_instruc), 64'h10);
            chk("mul_ops", 64'({bus.alu_a, bus.alu_b}), {32'h0005_4351, 32'h0000_4351});
            chk("mul_pending", 64'(bus.rsp_valid), 64'd0);
            step();
        end
        chk("mul_valid", 64'(bus.rsp_valid), 64'd1);
        chk("mul_lo", 64'(bus.rsp_lo), 64'h6248_7FA1);
        chk("mul_hi", 64'(bus.rsp_hi), 64'h1);
        chk("mul_id", 64'(bus.rsp_id), 64'd1);
        step();

        // Round-robin with both requesters always asking.
        do_reset();
        set_req(0, 4'd3, 32'hA, 32'hF);
        set_req(1, 4'd3, 32'hA, 32'hF);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(10);
            chk("arb_id", 64'(bus.rsp_id), 64'(k % 2));
            chk("arb_lo", 64'(bus.rsp_lo), 64'hFFFF_FFFB);
            step();
        end
        bus.req_valid = 2'b00;
        step();

        // Illegal opcode: immediate error response, ALU untouched.
        set_req(0, 4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
        step();
        bus.req_valid = 2'b00;
        chk("ill_valid", 64'(bus.rsp_valid), 64'd1);
        chk("ill_err", 64'(bus.rsp_err), 64'd1);
        chk("ill_lohi", 64'({bus.rsp_lo, bus.rsp_hi}), 64'd0);
        chk("ill_carry", 64'(bus.rsp_carry), 64'd0);
        chk("ill_instruc", 64'(bus.alu_instruc), 64'd0);
        step();

        // Backpressure on a ROL result.
        bus.rsp_ready = 1'b0;
        set_req(0, 4'd10, 32'h8000_0001, 32'hA);
        step();
        bus.req_valid = 2'b00;
        step();
        set_req(0, 4'd0, 32'h1, 32'h1);
        set_req(1, 4'd1, 32'h2, 32'h2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_lo", 64'(bus.rsp_lo), 64'h0000_0600);
            chk("bp_ready", 64'(bus.req_ready_c), 64'd0);
            step();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_idle", 64'(bus.busy), 64'd0);
        chk("bp_dropped", 64'(bus.rsp_valid), 64'd0);
        chk("bp_lo_kept", 64'(bus.rsp_lo), 64'h0000_0600);

        // Reset in the second MUL EXEC cycle, then a clean AND.
        set_req(0, 4'd4, 32'h7, 32'h9);
        step();
        bus.req_valid = 2'b00;
        step();
        set_req(0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_reset();
        set_req(0, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        bus.req_valid = 2'b00;
        wait_rsp(10);
        chk("and_lo", 64'(bus.rsp_lo), 64'hFFFF_FFFF);
        step();

        // Randomized traffic; requesters hold requests until granted.
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (tb_granted[r]) bus.req_valid[r] = 1'b0;
                if (!bus.req_valid[r] && $urandom_range(0, 2) == 0)
                    set_req(r, 4'($urandom_range(0, 15)), $urandom,
                            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Front-end controller for the shared one-hot-select ALU. It accepts operation requests from two requesters, such as the datapath control unit and a debug/test port, and grants them round-robin. It decodes a 4-bit opcode into the ALU's 13-bit one-hot select and holds operands stable for a programmable number of cycles on MUL/DIV. It captures result, result_hi and carryOut into a response register that is held until the owner accepts it.

## Interface
- WIDTH, 32, operand/result width
- MULDIV_CYCLES, 4, EXEC cycles for MUL/DIV (≥1); all other ops take 1

- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i = requester i has a request
- req_ready  out  2  bit i = request i accepted this cycle
- req_op0, req_op1  in  4  opcode per requester
- req_a0, req_a1, req_b0, req_b1  in  WIDTH  operands per requester
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that owns the response
- rsp_lo, rsp_hi  out  WIDTH  captured result / result_hi
- rsp_carry  out  1  captured carryOut
- rsp_err  out  1  illegal opcode
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_instruc  out  13  one-hot ALU select
- alu_result, alu_result_hi  in  WIDTH  ALU outputs
- alu_carry  in  1  ALU carryOut
- busy  out  1  state ≠ IDLE

## Operation
- Opcode → alu_instruc bit: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT. Opcodes 13–15 are illegal.
- FSM states:
  - IDLE:
    - req_ready is combinational and nonzero only here.
    - One valid request → grant it.
    - Both valid → grant the requester not granted last (last_grant register).
    - On the accept edge, register op/a/b and the grant id.
    - Legal op → EXEC with cnt = MULDIV_CYCLES for MUL/DIV, else 1.
    - Illegal op → DONE with err=1, lo=hi=0, carry=0, no ALU drive.
  - EXEC:
    - alu_instruc = one-hot(op_q); alu_a/alu_b = registered operands, stable for every EXEC cycle.
    - cnt decrements each cycle.
    - At cnt==1, on the clock edge: capture alu_result → rsp_lo, alu_result_hi → rsp_hi, alu_carry → rsp_carry, clear err, go to DONE.
  - DONE:
    - rsp_valid=1; rsp_* and rsp_id held stable.
    - rsp_ready=1 → IDLE and last_grant ← rsp_id.
- alu_instruc = 0 and alu_a = alu_b = 0 outside EXEC, so the ALU is never selected spuriously.
- rsp_* registers keep their last value after the handshake; only rsp_valid drops.
- Requests are never lost. An ungranted requester keeps req_valid high and is served next.
- Requests are not accepted while busy; req_ready = 0 in EXEC and DONE.
- Operands, op and opcode are sampled only on the accept edge; later changes on req_* are ignored.

## Timing
- clear_n low (asynchronous):
  - state ← IDLE, last_grant ← 1 (requester 0 wins the first tie), cnt ← 0.
  - All outputs 0: req_ready, rsp_*, alu_*, busy.
- Accept at edge T:
  - EXEC occupies cycles T..T+N−1 (N = 1 or MULDIV_CYCLES).
  - Capture at edge T+N; rsp_valid high from T+N.
  - Illegal opcode: rsp_valid high from T (no EXEC).
- Response consumed at edge D (rsp_valid & rsp_ready): state is IDLE after D, and a new request can be accepted at edge D+1.
  - Steady-state throughput with rsp_ready held high: one op per N+2 cycles.
- rsp_valid with rsp_ready low holds indefinitely; no timeout.
- Reset mid-EXEC or mid-DONE aborts the operation. The response is discarded and the next request after clear_n rises is accepted normally.
- MULDIV_CYCLES = 1 makes MUL/DIV identical in timing to single-cycle ops.

## Test plan
- ADD: req0 op 2, A=B=0xFFFFFFFF.
  - Expect rsp_lo=0xFFFFFFFE, rsp_carry=1, rsp_id=0.
  - rsp_valid rises 1 cycle after accept.
  - alu_instruc=13'b0000000000100 for exactly 1 cycle.
- MUL, MULDIV_CYCLES=4: req1 op 4, A=0x00054351, B=0x00004351.
  - alu_instruc=13'b0000000010000 and operands stable for 4 cycles.
  - rsp_lo=0x62487FA1, rsp_hi=0x00000001, rsp_id=1, rsp_valid 4 cycles after accept.
- Arbitration: both req_valid held high with SUB (op 3, A=0xA, B=0xF) on each.
  - Grants alternate 0,1,0,1 starting with 0 after reset.
  - rsp_lo=0xFFFFFFFB each time.
- Illegal opcode 14 from req0:
  - rsp_err=1, rsp_lo=rsp_hi=0, rsp_carry=0.
  - alu_instruc stays 0 throughout.
  - rsp_valid high from the accept edge.
- Backpressure: ROL (op 10) A=0x80000001, B=0xA, with rsp_ready low for 5 cycles.
  - rsp_lo=0x00000600 held stable, rsp_valid high.
  - req_ready=2'b00 during the stall.
  - Returns to IDLE one edge after rsp_ready.
- Reset mid-EXEC (MUL, cycle 2):
  - All outputs 0 immediately on clear_n low, state IDLE.
  - After release, AND 0xFFFFFFFF & 0xFFFFFFFF gives rsp_lo=0xFFFFFFFF.
